fht_unloader: RTL and testbench

- Result-readout engine on the far side of the FHT core's memory interface: runs after `fht_control` reports conversion complete (RDY high).
- Reads the four data banks in natural output-index order and streams the samples out over a valid/ready interface.
- While busy, blocks a new FHT start.
- Absorbs the one-cycle synchronous RAM read latency under arbitrary downstream back-pressure via a 2-entry output buffer.

---
 rtl/fht_unloader.sv | 156 +++++++++++++++
 tb/tb_fht_unloader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_unloader.sv
// Streams the finished FHT result out of the four data banks in natural index order.
// A 2-entry output buffer absorbs the one-cycle RAM read latency under back-pressure.
module fht_unloader #(
    parameter int unsigned A_BIT = 8,
    parameter int unsigned D_BIT = 16
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iUNLOAD,
    input  logic               iFHT_RDY,
    output logic               oBUSY,
    output logic               oRD_EN,
    output logic [A_BIT-1:0]   oADDR_RD,
    input  logic [D_BIT-1:0]   iDATA_0,
    input  logic [D_BIT-1:0]   iDATA_1,
    input  logic [D_BIT-1:0]   iDATA_2,
    input  logic [D_BIT-1:0]   iDATA_3,
    output logic [D_BIT-1:0]   oDATA,
    output logic               oVALID,
    input  logic               iREADY,
    output logic               oLAST,
    output logic [A_BIT+1:0]   oINDEX
);

    localparam int unsigned IW = A_BIT + 2;
    localparam logic [IW-1:0] LastIdx = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e              state_q;
    logic   [IW-1:0]     cnt_q;
    logic                busy_q;
    logic                pend_q;
    logic   [IW-1:0]     pend_idx_q;

    logic   [D_BIT-1:0]  data_q [2];
    logic   [IW-1:0]     idx_q  [2];
    logic                last_q [2];
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic   [1:0]        occ_q;

    logic                push;
    logic                pop;
    logic                issue;
    logic   [2:0]        load;
    logic   [D_BIT-1:0]  rd_data;
    logic                head_last;

    assign push      = pend_q;
    assign oVALID    = (occ_q != 2'd0);
    assign pop       = oVALID && iREADY;
    assign head_last = last_q[rd_ptr_q];

    // Occupancy after this edge's pop plus the read returning now; a new read
    // may only be issued if a slot will be free when it lands.
    assign load  = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign issue = (state_q == StRun) && (load < 3'd2);

    // Left combinational: gating on this cycle's pop is what keeps the stream bubble-free.
    assign oRD_EN   = issue;
    assign oADDR_RD = cnt_q[IW-1:2];
    assign oBUSY    = busy_q;

    assign oDATA  = data_q[rd_ptr_q];
    assign oINDEX = idx_q[rd_ptr_q];
    assign oLAST  = head_last;

    // Bank select travels with the read so the right bank is captured a cycle later.
    always_comb begin
        rd_data = iDATA_0;
        unique case (pend_idx_q[1:0])
            2'd0: rd_data = iDATA_0;
            2'd1: rd_data = iDATA_1;
            2'd2: rd_data = iDATA_2;
            2'd3: rd_data = iDATA_3;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            pend_q <= issue;
            if (issue) begin
                pend_idx_q <= cnt_q;
            end
            case (state_q)
                StIdle: begin
                    if (iUNLOAD && iFHT_RDY) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (cnt_q == LastIdx) begin
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + IW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (pop && head_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= rd_data;
                idx_q[wr_ptr_q]  <= pend_idx_q;
                last_q[wr_ptr_q] <= (pend_idx_q == LastIdx);
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge iCLK) disable iff (!iRESET)
        (push && !pop) |-> (occ_q < 2'd2));
`endif

endmodule

// File: tb/tb_fht_unloader.sv
// Scoreboard bench for fht_unloader: a RAM model feeds the banks, stimulus queues
// the expected stream, and a negedge monitor checks every accepted word.
module tb_fht_unloader;

    localparam int A_BIT = 8;
    localparam int D_BIT = 16;
    localparam int N     = 4 * (1 << A_BIT);

    typedef struct packed {
        logic [D_BIT-1:0] data;
        logic [A_BIT+1:0] idx;
        logic             last;
    } exp_t;

    logic               iCLK = 1'b0;
    logic               iRESET = 1'b0;
    logic               iUNLOAD = 1'b0;
    logic               iFHT_RDY = 1'b0;
    logic               iREADY = 1'b0;
    logic               oBUSY, oRD_EN, oVALID, oLAST;
    logic [A_BIT-1:0]   oADDR_RD;
    logic [D_BIT-1:0]   iDATA_0 = '0, iDATA_1 = '0, iDATA_2 = '0, iDATA_3 = '0;
    logic [D_BIT-1:0]   oDATA;
    logic [A_BIT+1:0]   oINDEX;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   acc_cnt = 0;
    int   rd_cnt = 0;
    int   last_cnt = 0;
    int   ready_mode = 0;
    exp_t exp_q[$];

    fht_unloader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iUNLOAD(iUNLOAD), .iFHT_RDY(iFHT_RDY),
        .oBUSY(oBUSY), .oRD_EN(oRD_EN), .oADDR_RD(oADDR_RD),
        .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iDATA_2(iDATA_2), .iDATA_3(iDATA_3),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oLAST(oLAST), .oINDEX(oINDEX)
    );

    always #5 iCLK = ~iCLK;

    // Bank b, address a holds 4a+b, so the natural-order stream reads back 0..N-1.
    initial begin
        forever begin
            @(posedge iCLK);
            if (oRD_EN) begin
                iDATA_0 <= D_BIT'({oADDR_RD, 2'd0});
                iDATA_1 <= D_BIT'({oADDR_RD, 2'd1});
                iDATA_2 <= D_BIT'({oADDR_RD, 2'd2});
                iDATA_3 <= D_BIT'({oADDR_RD, 2'd3});
            end
        end
    end

    initial begin
        forever begin
            @(posedge iCLK);
            #1;
            case (ready_mode)
                0:       iREADY = 1'b0;
                1:       iREADY = 1'b1;
                default: iREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #2;
    endtask

    task automatic push_stream();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = D_BIT'(k);
            e.idx  = (A_BIT + 2)'(k);
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_unload();
        iUNLOAD = 1'b1;
        step();
        iUNLOAD = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (oBUSY && c < budget) begin
            step();
            c++;
        end
        check("idle_reached", 32'(oBUSY), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(oBUSY), 0);
        check({tag, "_rd_en"}, 32'(oRD_EN), 0);
        check({tag, "_addr"},  32'(oADDR_RD), 0);
        check({tag, "_valid"}, 32'(oVALID), 0);
        check({tag, "_last"},  32'(oLAST), 0);
        check({tag, "_data"},  32'(oDATA), 0);
        check({tag, "_index"}, 32'(oINDEX), 0);
    endtask

    // Monitor: independent occupancy/in-flight model plus scoreboard pop on handoff.
    initial begin
        int   occ = 0;
        int   pend = 0;
        int   nocc;
        logic pop;
        logic prev_stall = 1'b0;
        logic [D_BIT-1:0] prev_data = '0;
        logic [A_BIT+1:0] prev_idx = '0;
        exp_t e;
        forever begin
            @(negedge iCLK);
            if (!iRESET) begin
                occ = 0;
                pend = 0;
                prev_stall = 1'b0;
            end else begin
                pop = oVALID && iREADY;
                check("valid_vs_occupancy", 32'(oVALID), 32'(occ != 0));
                if (prev_stall) begin
                    check("stall_valid", 32'(oVALID), 1);
                    check("stall_data", 32'(oDATA), 32'(prev_data));
                    check("stall_index", 32'(oINDEX), 32'(prev_idx));
                end
                if (pop) begin
                    acc_cnt++;
                    if (oLAST) last_cnt++;
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_word: got index %0d, expected no word", oINDEX);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", 32'(oDATA), 32'(e.data));
                        check("word_index", 32'(oINDEX), 32'(e.idx));
                        check("word_last", 32'(oLAST), 32'(e.last));
                    end
                end
                nocc = occ + pend - (pop ? 1 : 0);
                if (oRD_EN) begin
                    rd_cnt++;
                    check("occ_plus_inflight_le2", 32'(nocc + 1 <= 2), 1);
                end
                occ = nocc;
                pend = oRD_EN ? 1 : 0;
                prev_stall = oVALID && !iREADY;
                prev_data = oDATA;
                prev_idx = oINDEX;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base_acc;
        int base_rd;
        int base_last;

        // Reset values
        #2;
        check_reset_outputs("reset");
        repeat (3) step();
        iRESET = 1'b1;
        iFHT_RDY = 1'b1;
        ready_mode = 1;
        repeat (2) step();

        // Full stream with iREADY held high: latency and bubble-free throughput
        base_acc = acc_cnt;
        base_last = last_cnt;
        push_stream();
        pulse_unload();
        n = 1;
        check("t1_busy_c1", 32'(oBUSY), 1);
        check("t1_rd_en_c1", 32'(oRD_EN), 1);
        check("t1_addr_c1", 32'(oADDR_RD), 0);
        step(); n++;
        check("t1_valid_c2", 32'(oVALID), 0);
        step(); n++;
        check("t1_valid_c3", 32'(oVALID), 1);
        check("t1_index_c3", 32'(oINDEX), 0);
        while (oBUSY && n < N + 50) begin
            step();
            n++;
        end
        check("t1_busy_fall_cycle", 32'(n), 32'(N + 3));
        check("t1_words", 32'(acc_cnt - base_acc), 32'(N));
        check("t1_last_count", 32'(last_cnt - base_last), 1);
        check("t1_queue_empty", 32'(exp_q.size()), 0);

        // Unload without RDY is ignored
        iFHT_RDY = 1'b0;
        pulse_unload();
        for (int i = 0; i < 4; i++) begin
            check("nordy_busy", 32'(oBUSY), 0);
            check("nordy_rd_en", 32'(oRD_EN), 0);
            check("nordy_valid", 32'(oVALID), 0);
            step();
        end
        iFHT_RDY = 1'b1;

        // Back-pressure from the start: exactly two reads, then resume at index 2
        ready_mode = 0;
        repeat (2) step();
        base_acc = acc_cnt;
        base_rd = rd_cnt;
        push_stream();
        pulse_unload();
        check("stall_rd_en_c1", 32'(oRD_EN), 1);
        check("stall_addr_c1", 32'(oADDR_RD), 0);
        step();
        check("stall_rd_en_c2", 32'(oRD_EN), 1);
        check("stall_addr_c2", 32'(oADDR_RD), 0);
        repeat (18) step();
        check("stall_reads", 32'(rd_cnt - base_rd), 2);
        check("stall_rd_en_off", 32'(oRD_EN), 0);
        check("stall_head_index", 32'(oINDEX), 0);
        ready_mode = 1;
        wait_idle(N + 100);
        check("stall_words", 32'(acc_cnt - base_acc), 32'(N));
        check("stall_queue_empty", 32'(exp_q.size()), 0);

        // Random back-pressure, a second unload mid-stream, RDY dropping mid-stream
        ready_mode = 2;
        repeat (2) step();
        base_acc = acc_cnt;
        push_stream();
        pulse_unload();
        for (n = 1; n < 300; n++) begin
            if (n == 100) iUNLOAD = 1'b1;
            if (n == 101) iUNLOAD = 1'b0;
            if (n == 200) iFHT_RDY = 1'b0;
            step();
        end
        wait_idle(20 * N);
        iFHT_RDY = 1'b1;
        repeat (10) step();
        check("rand_words", 32'(acc_cnt - base_acc), 32'(N));
        check("rand_queue_empty", 32'(exp_q.size()), 0);
        check("rand_idle_valid", 32'(oVALID), 0);

        // Reset mid-stream, then a clean full restart
        ready_mode = 1;
        repeat (2) step();
        base_acc = acc_cnt;
        push_stream();
        pulse_unload();
        n = 0;
        while ((acc_cnt - base_acc) < 500 && n < 2 * N) begin
            step();
            n++;
        end
        check("rst_reached_500", 32'(acc_cnt - base_acc >= 500), 1);
        iRESET = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        repeat (3) step();
        iRESET = 1'b1;
        repeat (2) step();
        base_acc = acc_cnt;
        base_last = last_cnt;
        push_stream();
        pulse_unload();
        wait_idle(N + 100);
        check("rst_words", 32'(acc_cnt - base_acc), 32'(N));
        check("rst_last_count", 32'(last_cnt - base_last), 1);
        check("rst_queue_empty", 32'(exp_q.size()), 0);

        // Back-to-back unloads
        base_acc = acc_cnt;
        base_last = last_cnt;
        push_stream();
        pulse_unload();
        wait_idle(N + 100);
        push_stream();
        pulse_unload();
        check("b2b_restart_busy", 32'(oBUSY), 1);
        wait_idle(N + 100);
        repeat (5) step();
        check("b2b_words", 32'(acc_cnt - base_acc), 32'(2 * N));
        check("b2b_last_count", 32'(last_cnt - base_last), 2);
        check("b2b_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
